// File: rtl/exibe_sequencia_if.sv
// Handshake and memory-read bundle between the play FSM and the playback sequencer.
interface exibe_sequencia_if;
    logic       iniciar;
    logic       cancela;
    logic [3:0] rodada;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [2:0] db_estado;
    logic [3:0] db_endereco;

    modport master (
        output iniciar, cancela, rodada, mem_dado,
        input  mem_endereco, leds, exibindo, pronto, db_estado, db_endereco
    );

    modport slave (
        input  iniciar, cancela, rodada, mem_dado,
        output mem_endereco, leds, exibindo, pronto, db_estado, db_endereco
    );
endinterface

// File: rtl/exibe_sequencia.sv
// Plays back moves 0..rodada from the sequence RAM on the LEDs, each lit for
// T_ON cycles followed by a T_OFF dark gap, then pulses pronto.
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// LE      | address presented to the RAM
// ESPERA  | read data valid, loaded into leds
// MOSTRA  | move lit for T_ON cycles
// APAGA   | dark gap for T_OFF cycles
// PROXIMO | last move done? else advance address
// FIM     | pronto pulse, back to idle
module exibe_sequencia #(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 250
) (
    input logic              clock,
    input logic              reset,
    exibe_sequencia_if.slave bus
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LE      = 3'd1,
        ESPERA  = 3'd2,
        MOSTRA  = 3'd3,
        APAGA   = 3'd4,
        PROXIMO = 3'd5,
        FIM     = 3'd6
    } estado_t;

    localparam logic [15:0] ON_ULTIMO  = 16'(T_ON - 1);
    localparam logic [15:0] OFF_ULTIMO = 16'(T_OFF - 1);

    estado_t     estado, estado_prox;
    logic [15:0] timer, timer_prox;
    logic [3:0]  endereco, endereco_prox;
    logic [3:0]  leds_q, leds_prox;
    logic [3:0]  rodada_lat, rodada_prox;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            timer      <= '0;
            endereco   <= '0;
            leds_q     <= '0;
            rodada_lat <= '0;
        end else begin
            estado     <= estado_prox;
            timer      <= timer_prox;
            endereco   <= endereco_prox;
            leds_q     <= leds_prox;
            rodada_lat <= rodada_prox;
        end
    end

    always_comb begin
        estado_prox   = estado;
        timer_prox    = timer;
        endereco_prox = endereco;
        leds_prox     = leds_q;
        rodada_prox   = rodada_lat;

        // Abort has priority, including over iniciar while idle.
        if (bus.cancela) begin
            estado_prox   = OCIOSO;
            timer_prox    = '0;
            endereco_prox = '0;
            leds_prox     = '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    timer_prox    = '0;
                    endereco_prox = '0;
                    leds_prox     = '0;
                    if (bus.iniciar) begin
                        rodada_prox = bus.rodada;
                        estado_prox = LE;
                    end
                end
                LE: begin
                    estado_prox = ESPERA;
                end
                ESPERA: begin
                    leds_prox   = bus.mem_dado;
                    timer_prox  = '0;
                    estado_prox = MOSTRA;
                end
                MOSTRA: begin
                    if (timer == ON_ULTIMO) begin
                        leds_prox   = '0;
                        timer_prox  = '0;
                        estado_prox = APAGA;
                    end else begin
                        timer_prox = timer + 16'd1;
                    end
                end
                APAGA: begin
                    leds_prox = '0;
                    if (timer == OFF_ULTIMO) begin
                        timer_prox  = '0;
                        estado_prox = PROXIMO;
                    end else begin
                        timer_prox = timer + 16'd1;
                    end
                end
                PROXIMO: begin
                    // Compare before incrementing so rodada=15 never wraps the address.
                    if (endereco == rodada_lat) begin
                        estado_prox = FIM;
                    end else begin
                        endereco_prox = endereco + 4'd1;
                        estado_prox   = LE;
                    end
                end
                FIM: begin
                    endereco_prox = '0;
                    estado_prox   = OCIOSO;
                end
                default: begin
                    timer_prox    = '0;
                    endereco_prox = '0;
                    leds_prox     = '0;
                    estado_prox   = OCIOSO;
                end
            endcase
        end
    end

    assign bus.mem_endereco = endereco;
    assign bus.db_endereco  = endereco;
    assign bus.leds         = leds_q;
    assign bus.db_estado    = estado;
    assign bus.pronto       = (estado == FIM);
    assign bus.exibindo     = (estado != OCIOSO) && (estado != FIM);

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: table-driven playback runs, random runs against a
// timeline model, and hand-written abort / async-reset sequences.
module tb_exibe_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int P     = T_ON + T_OFF + 3;

    typedef struct {
        logic [3:0]  rodada;
        logic [63:0] img;
        int          pronto_edge;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    logic [3:0] mem [16];
    int checks   = 0;
    int failures = 0;

    exibe_sequencia_if bus();

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM: data appears one edge after the address.
    always @(posedge clock) bus.mem_dado <= mem[bus.mem_endereco];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_img(input logic [63:0] img);
        for (int i = 0; i < 16; i++) mem[i] = img[4*i +: 4];
    endtask

    // Expected outputs e edges after the edge that sampled iniciar.
    function automatic void model(input int e, input int lr,
                                  output logic [3:0] leds, output logic [3:0] addr,
                                  output logic exib, output logic pr);
        int m, r;
        leds = 4'd0; addr = 4'd0; exib = 1'b0; pr = 1'b0;
        if (e < (lr + 1) * P) begin
            m    = e / P;
            r    = e % P;
            addr = 4'(m);
            exib = 1'b1;
            if (r >= 2 && r <= T_ON + 1) leds = mem[m];
        end else if (e == (lr + 1) * P) begin
            addr = 4'(lr);
            pr   = 1'b1;
        end
    endfunction

    task automatic run_check(input int lr, input int dist_e, input int dist_rod, input int exp_pe);
        int pr_cnt = 0;
        int pr_edge = -1;
        logic [3:0] el, ea;
        logic ex, ep;
        bus.rodada  = 4'(lr);
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        for (int e = 0; e <= (lr + 1) * P + 3; e++) begin
            if (e > 0) step();
            if (e == dist_e + 1) bus.iniciar = 1'b0;
            model(e, lr, el, ea, ex, ep);
            chk("leds", 32'(bus.leds), 32'(el));
            chk("mem_endereco", 32'(bus.mem_endereco), 32'(ea));
            chk("db_endereco", 32'(bus.db_endereco), 32'(ea));
            chk("exibindo", 32'(bus.exibindo), 32'(ex));
            chk("pronto", 32'(bus.pronto), 32'(ep));
            if (bus.pronto) begin
                pr_cnt++;
                pr_edge = e;
            end
            if (e == dist_e) begin
                bus.iniciar = 1'b1;
                bus.rodada  = 4'(dist_rod);
            end
        end
        bus.iniciar = 1'b0;
        chk("pronto_count", 32'(pr_cnt), 32'd1);
        if (exp_pe >= 0) chk("pronto_edge", 32'(pr_edge), 32'(exp_pe));
    endtask

    initial begin
        vec_t vecs[4];
        int cnt;
        logic [63:0] rimg;

        vecs[0] = '{rodada: 4'd2,  img: 64'h0000_0000_0000_0421, pronto_edge: 27};
        vecs[1] = '{rodada: 4'd0,  img: 64'h0000_0000_0000_0008, pronto_edge: 9};
        vecs[2] = '{rodada: 4'd15, img: 64'hFEDC_BA98_7654_3210, pronto_edge: 144};
        vecs[3] = '{rodada: 4'd2,  img: 64'h0000_0000_0000_0305, pronto_edge: 27};

        reset       = 1'b0;
        bus.iniciar = 1'b0;
        bus.cancela = 1'b0;
        bus.rodada  = 4'd0;
        load_img(64'd0);
        repeat (3) step();
        chk("rst_leds", 32'(bus.leds), 32'd0);
        chk("rst_addr", 32'(bus.mem_endereco), 32'd0);
        chk("rst_exibindo", 32'(bus.exibindo), 32'd0);
        chk("rst_pronto", 32'(bus.pronto), 32'd0);
        chk("rst_state", 32'(bus.db_estado), 32'd0);
        reset = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            load_img(vecs[v].img);
            run_check(int'(vecs[v].rodada), -1, 0, vecs[v].pronto_edge);
        end

        // iniciar re-pulsed and rodada changed mid-run must be ignored.
        load_img(64'h0000_0000_0000_0421);
        run_check(2, 12, 5, 27);

        // cancela together with iniciar while idle keeps the block idle.
        bus.cancela = 1'b1;
        bus.iniciar = 1'b1;
        step();
        chk("cancel_idle_state", 32'(bus.db_estado), 32'd0);
        chk("cancel_idle_exib", 32'(bus.exibindo), 32'd0);
        bus.cancela = 1'b0;
        bus.iniciar = 1'b0;
        step();
        chk("cancel_idle_state2", 32'(bus.db_estado), 32'd0);

        // Abort during the second move's on-time.
        bus.rodada  = 4'd2;
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        repeat (P + 3) step();
        chk("cancel_pre_leds", 32'(bus.leds), 32'd2);
        bus.cancela = 1'b1;
        step();
        bus.cancela = 1'b0;
        chk("cancel_state", 32'(bus.db_estado), 32'd0);
        chk("cancel_leds", 32'(bus.leds), 32'd0);
        chk("cancel_addr", 32'(bus.mem_endereco), 32'd0);
        chk("cancel_exib", 32'(bus.exibindo), 32'd0);
        cnt = 0;
        repeat (40) begin
            step();
            if (bus.pronto) cnt++;
        end
        chk("cancel_no_pronto", 32'(cnt), 32'd0);
        run_check(2, -1, 0, 27);

        // Async reset between edges during the second gap.
        load_img(64'h0000_0000_0000_0096);
        bus.rodada  = 4'd1;
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        repeat (P + 6) step();
        chk("areset_pre_state", 32'(bus.db_estado), 32'd4);
        chk("areset_pre_addr", 32'(bus.mem_endereco), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_state", 32'(bus.db_estado), 32'd0);
        chk("areset_addr", 32'(bus.mem_endereco), 32'd0);
        chk("areset_leds", 32'(bus.leds), 32'd0);
        chk("areset_exib", 32'(bus.exibindo), 32'd0);
        chk("areset_pronto", 32'(bus.pronto), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin
            step();
            if (bus.pronto) cnt++;
        end
        chk("areset_no_pronto", 32'(cnt), 32'd0);
        run_check(1, -1, 0, 18);

        // Random rounds, memory contents and mid-run disturbances.
        for (int k = 0; k < 8; k++) begin
            int lr, de;
            rimg = {$urandom(), $urandom()};
            load_img(rimg);
            lr = int'($urandom_range(0, 15));
            de = int'($urandom_range(1, (lr + 1) * P - 1));
            run_check(lr, de, int'($urandom_range(0, 15)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Playback side of the memory game: for the current round, reads stored moves from the 16x4 sequence memory at addresses 0..rodada.
- Shows each move on the LEDs for a fixed on-time, then an off-gap, so the player can reproduce the sequence on the chaves.
- Sits beside the play datapath and shares the same sync_ram_16x4_file contents.
- The play FSM pulses iniciar and waits for pronto before accepting player moves.

Parameters:
T_ON, 1000, clock cycles each move is lit (legal range 1..65535)
T_OFF, 250, clock cycles of dark gap after each move (legal range 1..65535)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset), clears all state
iniciar  input  1  start playback; sampled only in OCIOSO
cancela  input  1  synchronous abort; wins over every other input
rodada  input  4  index of last move to show (shows rodada+1 moves)
mem_dado  input  4  memory read data, valid one cycle after mem_endereco changes
mem_endereco  output  4  memory read address
leds  output  4  registered move display
exibindo  output  1  high in every state except OCIOSO and FIM
pronto  output  1  one-cycle pulse when the last gap ends
db_estado  output  3  state encoding for debug displays
db_endereco  output  4  copy of mem_endereco

Behaviour:
- Reset (reset=0, async) values:
  - state=OCIOSO, mem_endereco=0, leds=0, exibindo=0, pronto=0.
  - rodada latch=0, timer=0.
- States and db_estado codes:
  - OCIOSO=0, LE=1, ESPERA=2, MOSTRA=3, APAGA=4, PROXIMO=5, FIM=6.
- OCIOSO:
  - leds=0, mem_endereco=0.
  - On iniciar=1: latch rodada, go to LE.
- LE, 1 cycle:
  - Address stable; the RAM registers it at the end of this cycle.
- ESPERA, 1 cycle:
  - mem_dado is valid here; leds<=mem_dado at the closing edge.
  - Timer cleared.
- MOSTRA, exactly T_ON cycles:
  - leds hold the move; timer counts.
  - At count T_ON-1: leds<=0, timer cleared, go to APAGA.
- APAGA, exactly T_OFF cycles:
  - leds=0.
  - At count T_OFF-1: go to PROXIMO.
- PROXIMO, 1 cycle:
  - If mem_endereco==latched rodada: go to FIM.
  - Otherwise mem_endereco+=1 and go to LE.
- FIM, 1 cycle:
  - pronto=1, then return to OCIOSO.
- Cycle count per move: T_ON+T_OFF+3.
  - pronto is high in the cycle starting (rodada+1)*(T_ON+T_OFF+3) edges after the edge that sampled iniciar.
- Timer is 16 bits and never wraps within legal parameters.
- Boundary rules:
  - iniciar outside OCIOSO is ignored; no restart.
  - rodada changes after the latch are ignored.
  - rodada=0 shows one move (address 0).
  - rodada=15 shows 16 moves; the address never increments past 15.
  - A move value of 0 is displayed as dark LEDs and still consumes full T_ON timing.
  - cancela=1 in any state: next edge goes to OCIOSO with leds=0, mem_endereco=0, no pronto.
  - cancela and iniciar high together in OCIOSO: stay in OCIOSO.
  - reset going low mid-playback: immediate async clear; no pronto afterwards.

Test Plan:
- T_ON=4, T_OFF=2, memory 0..2 = 1,2,4, rodada=2, one iniciar pulse:
  - leds show 1, 2, 4, each for exactly 4 cycles, separated by 2+3 dark cycles.
  - pronto pulses once, 27 edges after iniciar; exibindo falls with pronto.
- rodada=0, memory[0]=8: leds=8 for 4 cycles, pronto at edge 9, mem_endereco never leaves 0.
- rodada=15, memory[i]=i:
  - leds sequence is 0 (dark), 1..15 across 16 moves.
  - mem_endereco reaches 15 and does not wrap; pronto at edge 144.
- Robustness of a run started with rodada=2:
  - iniciar re-pulsed and rodada changed to 5 mid-run: still exactly 3 moves, one pronto.
- Abort and reset mid-run:
  - cancela during the second MOSTRA: next cycle OCIOSO, leds=0, no pronto.
  - A following iniciar restarts from address 0.
- Async reset: reset=0 asserted between edges during APAGA clears outputs immediately, with no clock edge needed; normal operation resumes after release.
